// File: rtl/dmem_arb_fsm.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_fsm
// Brief   : Single-port data-memory arbiter between the load RS and the store
//           buffer, with a bounded store burst so waiting loads cannot starve.
// Revision: 1.0
// ============================================================================
module dmem_arb_fsm #(
  parameter int LOAD_IDX_W      = 3,
  parameter int STORE_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_load_rqst,
  input  logic [LOAD_IDX_W-1:0] i_load_idx,
  input  logic                  i_store_rqst,
  input  logic                  i_dmem_resp,
  output logic                  o_dmem_rqst,
  output logic                  o_dmem_we,
  output logic                  o_grant_load,
  output logic                  o_grant_store,
  output logic                  o_load_done,
  output logic [LOAD_IDX_W-1:0] o_load_done_idx,
  output logic                  o_store_pop,
  output logic                  o_busy
);

  localparam logic [3:0] c_burst_max = 4'(STORE_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_WAIT  = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LOAD_IDX_W-1:0] r_idx;
  logic [LOAD_IDX_W-1:0] w_idx_nxt;
  logic [3:0]            r_streak;
  logic [3:0]            w_streak_nxt;

  logic                  w_load_elig;
  logic                  w_store_elig;
  logic                  w_pick_load;
  logic                  w_pick_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Flush only squashes speculative loads; committed stores always proceed.
  assign w_load_elig  = i_load_rqst & ~i_flush;
  assign w_store_elig = i_store_rqst;
  assign w_pick_load  = w_load_elig & (~w_store_elig | (r_streak >= c_burst_max));
  assign w_pick_store = w_store_elig & ~w_pick_load;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_streak_nxt    = r_streak;
    o_dmem_rqst     = 1'b0;
    o_dmem_we       = 1'b0;
    o_grant_load    = 1'b0;
    o_grant_store   = 1'b0;
    o_load_done     = 1'b0;
    o_load_done_idx = '0;
    o_store_pop     = 1'b0;
    o_busy          = 1'b0;

    // Reset dominates: every output stays quiet while rst is high.
    if (!rst) begin
      o_busy = (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_pick_load) begin
            o_dmem_rqst  = 1'b1;
            o_grant_load = 1'b1;
            w_idx_nxt    = i_load_idx;
            w_streak_nxt = 4'd0;
            w_state_nxt  = RD_WAIT;
          end else if (w_pick_store) begin
            o_dmem_rqst   = 1'b1;
            o_dmem_we     = 1'b1;
            o_grant_store = 1'b1;
            w_state_nxt   = WR_WAIT;
            // Streak only grows while a load is actually being held off.
            if (!i_load_rqst) begin
              w_streak_nxt = 4'd0;
            end else if (r_streak < c_burst_max) begin
              w_streak_nxt = r_streak + 4'd1;
            end
          end
        end

        WR_WAIT: begin
          if (i_dmem_resp) begin
            o_store_pop = 1'b1;
            w_state_nxt = IDLE;
          end
        end

        RD_WAIT: begin
          if (i_dmem_resp) begin
            w_state_nxt = IDLE;
            if (!i_flush) begin
              o_load_done     = 1'b1;
              o_load_done_idx = r_idx;
            end
          end else if (i_flush) begin
            w_state_nxt = RD_DRAIN;
          end
        end

        RD_DRAIN: begin
          // The squashed load's response still has to come back before reuse.
          if (i_dmem_resp) begin
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
